conv_column_scheduler: RTL and testbench
========================================

Name: conv_column_scheduler

Overview:
- Sequences a 1-bit binary frame buffer (BRAM) into the 3x3 averaging convolution stage.
- For each output pixel (x,y) it reads the vertical 3-pixel column (rows y-1, y, y+1 at column x) and emits it as a 3-bit word with data_valid, hcount and vcount.
- It owns the BRAM read port and the frame start/done handshake. It sits between the frame buffer and the convolution stage.

Parameters:
- H_PIXELS, 320, frame width in pixels.
- V_PIXELS, 240, frame height in pixels.
- ADDR_W, 17, BRAM address width; must satisfy 2^ADDR_W >= H_PIXELS*V_PIXELS.
- BRAM_LATENCY, 2, cycles from a rd_en/address cycle to valid bram_data_in.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  reset; asynchronous, active-low.
- start_in  input  1  one-cycle pulse that starts a frame; ignored while busy_out=1.
- pause_in  input  1  while high, no new reads are issued; in-flight reads still complete.
- bram_addr_out  output  ADDR_W  read address = row*H_PIXELS + col.
- bram_rd_en_out  output  1  read strobe.
- bram_data_in  input  1  pixel read back, valid BRAM_LATENCY cycles after the strobe.
- data_out  output  3  column: [0]=row y-1, [1]=row y, [2]=row y+1.
- data_valid_out  output  1  data_out/hcount_out/vcount_out valid, one-cycle pulse per pixel.
- hcount_out  output  11  x of emitted column.
- vcount_out  output  10  y of emitted column.
- busy_out  output  1  frame in progress.
- done_out  output  1  one-cycle pulse at frame end.

Behaviour:
- Reset (async assert, sync deassert): FSM=IDLE, counters 0, tag pipe cleared.
  - All outputs 0: data_out, data_valid_out, hcount_out, vcount_out, bram_addr_out, bram_rd_en_out, busy_out, done_out.
- FSM IDLE -> RUN:
  - Taken on start_in=1 in IDLE.
  - busy_out=1 from the next cycle.
  - First issue slot occurs in that same next cycle.
- RUN, issue rules:
  - Each non-paused cycle issues one slot s in {0,1,2} for the current (x,y).
  - Slot s targets row r=y-1+s.
  - If 0<=r<V_PIXELS: bram_rd_en_out=1, bram_addr_out=r*H_PIXELS+x.
  - Otherwise (out of bounds): rd_en=0 and the slot is tagged as zero.
- RUN, counter advance:
  - After s=2: x increments. At x=H_PIXELS-1 it wraps to 0 and y increments.
  - After the slot-2 issue for (H_PIXELS-1, V_PIXELS-1), go to DRAIN.
- Paused cycles: no slot issued, counters hold, rd_en=0, and a bubble enters the tag pipe.
- Tag pipe:
  - Shift register of depth BRAM_LATENCY carrying {valid, slot, oob, x, y}.
  - At its tail, bit[slot] of the column assembler is loaded with bram_data_in, or 0 if oob.
  - When slot 2 lands, the next cycle drives data_out, hcount_out, vcount_out and pulses data_valid_out.
- Latency: slot-2 issue at cycle t gives data_valid_out at t+BRAM_LATENCY+1.
  - Unpaused, columns are emitted every 3 cycles.
- DRAIN -> DONE: taken when the tag pipe is empty and the final column has been emitted.
  - The cycle after the final data_valid_out: done_out=1, busy_out=0, FSM returns to IDLE.
  - Total unpaused frame: 3*H_PIXELS*V_PIXELS issue cycles.
- Outputs hold between pulses: data_out, hcount_out and vcount_out keep their last values while data_valid_out=0.
- Simultaneous events:
  - start_in in the same cycle as done_out is ignored; start must arrive in IDLE.
  - pause_in during DRAIN has no effect.
- Reset mid-frame: everything clears immediately. In-flight BRAM returns are discarded and no done_out is produced.

Test Plan (H_PIXELS=4, V_PIXELS=3, BRAM_LATENCY=2, BRAM model):
- All-ones frame, start at cycle 0:
  - Exactly 12 data_valid_out pulses, first at cycle 6, spaced 3 cycles.
  - Row 0 gives data_out=3'b110; row 1 gives 3'b111; row 2 gives 3'b011.
  - done_out at cycle 40; busy_out high for cycles 1-39.
- Single 1 at (2,1):
  - Only (2,0)=3'b100, (2,1)=3'b010 and (2,2)=3'b001 are nonzero.
  - Addresses 6, 2, 10 appear in the matching slots.
- pause_in held high for 5 cycles mid-frame:
  - bram_rd_en_out stays 0 during the pause.
  - The pixel sequence and values are unchanged, and done_out is delayed by exactly 5 cycles.
- start_in pulsed again while busy: no effect.
  - Start after done: a second identical frame follows.
- rst_n_in low at cycle 15:
  - All outputs 0 asynchronously; no further data_valid_out and no done_out.
  - A new start after release runs a full clean frame.
- Out-of-bounds check at y=0 and y=V_PIXELS-1:
  - bram_rd_en_out=0 for slot 0 and slot 2 respectively.
  - The corresponding data_out bit is 0 even when bram_data_in is driven 1.

Source files
------------

// File: rtl/conv_column_scheduler.sv
// Walks a 1-bit frame buffer column by column, issuing three vertical reads per pixel
// and reassembling the returned bits into 3-bit columns for the 3x3 averaging stage.
module conv_column_scheduler #(
    parameter int H_PIXELS     = 320,
    parameter int V_PIXELS     = 240,
    parameter int ADDR_W       = 17,
    parameter int BRAM_LATENCY = 2
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              start_in,
    input  logic              pause_in,
    output logic [ADDR_W-1:0] bram_addr_out,
    output logic              bram_rd_en_out,
    input  logic              bram_data_in,
    output logic [2:0]        data_out,
    output logic              data_valid_out,
    output logic [10:0]       hcount_out,
    output logic [9:0]        vcount_out,
    output logic              busy_out,
    output logic              done_out
);

    localparam logic [10:0]       X_LAST = 11'(H_PIXELS - 1);
    localparam logic [9:0]        Y_LAST = 10'(V_PIXELS - 1);
    localparam logic [10:0]       V_LIM  = 11'(V_PIXELS);
    localparam logic [ADDR_W-1:0] H_MUL  = ADDR_W'(H_PIXELS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic        valid;
        logic [1:0]  slot;
        logic        oob;
        logic [10:0] x;
        logic [9:0]  y;
    } tag_t;

    state_t      state_reg, state_next;
    logic [10:0] x_reg, x_next;
    logic [9:0]  y_reg, y_next;
    logic [1:0]  slot_reg, slot_next;

    logic        issue;
    logic [10:0] row;
    logic        row_oob;
    tag_t        issue_tag;
    tag_t        tail_tag;
    logic [BRAM_LATENCY-1:0] pipe_valid;
    logic        landed_bit;

    logic [1:0]  col_reg;
    logic [2:0]  data_reg;
    logic        valid_reg;
    logic [10:0] hcount_reg;
    logic [9:0]  vcount_reg;

    // Row may go to -1 for slot 0 at y=0; the 11-bit wrap makes it compare as out of range.
    always_comb begin
        issue          = (state_reg == S_RUN) && !pause_in;
        row            = {1'b0, y_reg} + {9'b0, slot_reg} - 11'd1;
        row_oob        = (row >= V_LIM);
        bram_rd_en_out = issue && !row_oob;
        bram_addr_out  = '0;
        if (bram_rd_en_out) begin
            bram_addr_out = ADDR_W'(row) * H_MUL + ADDR_W'(x_reg);
        end
        issue_tag.valid = issue;
        issue_tag.slot  = slot_reg;
        issue_tag.oob   = row_oob;
        issue_tag.x     = x_reg;
        issue_tag.y     = y_reg;
    end

    // Tag pipe: one stage per BRAM latency cycle; paused/drain cycles shift in bubbles.
    genvar gi;
    generate
        for (gi = 0; gi < BRAM_LATENCY; gi++) begin : g_stage
            tag_t stage_reg;
            if (gi == 0) begin : g_head
                always_ff @(posedge clk_in or negedge rst_n_in) begin
                    if (!rst_n_in) begin
                        stage_reg <= '0;
                    end else begin
                        stage_reg <= issue_tag;
                    end
                end
            end else begin : g_body
                always_ff @(posedge clk_in or negedge rst_n_in) begin
                    if (!rst_n_in) begin
                        stage_reg <= '0;
                    end else begin
                        stage_reg <= g_stage[gi-1].stage_reg;
                    end
                end
            end
            assign pipe_valid[gi] = stage_reg.valid;
        end
    endgenerate

    assign tail_tag   = g_stage[BRAM_LATENCY-1].stage_reg;
    assign landed_bit = bram_data_in && !tail_tag.oob;

    // Column assembler: slots 0/1 are parked, slot 2 completes the column and emits it.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            col_reg    <= '0;
            data_reg   <= '0;
            valid_reg  <= 1'b0;
            hcount_reg <= '0;
            vcount_reg <= '0;
        end else begin
            valid_reg <= 1'b0;
            if (tail_tag.valid) begin
                case (tail_tag.slot)
                    2'd0: col_reg[0] <= landed_bit;
                    2'd1: col_reg[1] <= landed_bit;
                    default: begin
                        data_reg   <= {landed_bit, col_reg};
                        hcount_reg <= tail_tag.x;
                        vcount_reg <= tail_tag.y;
                        valid_reg  <= 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg <= S_IDLE;
            x_reg     <= '0;
            y_reg     <= '0;
            slot_reg  <= '0;
        end else begin
            state_reg <= state_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            slot_reg  <= slot_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        slot_next  = slot_reg;
        case (state_reg)
            S_IDLE: begin
                if (start_in) begin
                    state_next = S_RUN;
                    x_next     = '0;
                    y_next     = '0;
                    slot_next  = '0;
                end
            end
            S_RUN: begin
                if (issue) begin
                    if (slot_reg == 2'd2) begin
                        slot_next = '0;
                        if (x_reg == X_LAST) begin
                            x_next = '0;
                            if (y_reg == Y_LAST) begin
                                y_next     = '0;
                                state_next = S_DRAIN;
                            end else begin
                                y_next = y_reg + 10'd1;
                            end
                        end else begin
                            x_next = x_reg + 11'd1;
                        end
                    end else begin
                        slot_next = slot_reg + 2'd1;
                    end
                end
            end
            // Pipe empties in the same cycle the final column is on the outputs.
            S_DRAIN: begin
                if (pipe_valid == '0) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign busy_out       = (state_reg == S_RUN) || (state_reg == S_DRAIN);
    assign done_out       = (state_reg == S_DONE);
    assign data_out       = data_reg;
    assign data_valid_out = valid_reg;
    assign hcount_out     = hcount_reg;
    assign vcount_out     = vcount_reg;

endmodule

// File: tb/tb_conv_column_scheduler.sv
// Bench for conv_column_scheduler on a 4x3 frame with a 2-cycle BRAM model; expected
// columns and read addresses are queued from an image model and popped as the DUT emits.
module tb_conv_column_scheduler;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int L  = 2;
    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          rst_n_in = 1'b0;
    logic          start_in = 1'b0;
    logic          pause_in = 1'b0;
    logic [AW-1:0] bram_addr_out;
    logic          bram_rd_en_out;
    logic          bram_data_in;
    logic [2:0]    data_out;
    logic          data_valid_out;
    logic [10:0]   hcount_out;
    logic [9:0]    vcount_out;
    logic          busy_out;
    logic          done_out;

    int n_checks = 0;
    int n_pass   = 0;

    logic img [0:H*V-1];
    logic force_one = 1'b0;
    logic s1 = 1'b0;
    logic s2 = 1'b0;

    conv_column_scheduler #(
        .H_PIXELS(H), .V_PIXELS(V), .ADDR_W(AW), .BRAM_LATENCY(L)
    ) dut (
        .clk_in(clk), .rst_n_in(rst_n_in), .start_in(start_in), .pause_in(pause_in),
        .bram_addr_out(bram_addr_out), .bram_rd_en_out(bram_rd_en_out),
        .bram_data_in(bram_data_in), .data_out(data_out), .data_valid_out(data_valid_out),
        .hcount_out(hcount_out), .vcount_out(vcount_out), .busy_out(busy_out),
        .done_out(done_out)
    );

    always #5 clk = ~clk;

    // BRAM model: two registered stages from strobe to data.
    always @(posedge clk) begin
        s1 <= (bram_rd_en_out && int'(bram_addr_out) < H*V) ? img[int'(bram_addr_out)] : 1'b0;
        s2 <= s1;
    end
    assign bram_data_in = force_one | s2;

    function automatic logic pix(input int y, input int x);
        return force_one | img[y*H + x];
    endfunction

    task automatic fill_img(input int mode);
        for (int i = 0; i < H*V; i++) begin
            case (mode)
                0: img[i] = 1'b0;
                1: img[i] = 1'b1;
                default: img[i] = 1'($urandom_range(0, 1));
            endcase
        end
    endtask

    task automatic run_frame(input string name, input int pause_at, input int pause_len,
                             input int reset_at, input bit poke_start);
        logic [23:0] exp_q[$];
        int          addr_q[$];
        logic [23:0] got, want;
        logic        b0, b1, b2, exp_busy;
        int exp_done, end_rel, first_valid, last_valid, n_valid, done_cyc, n_done;
        int busy_bad, space_bad, post_rst_bad, a, r;

        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                b0 = (y > 0)     ? pix(y-1, x) : 1'b0;
                b1 = pix(y, x);
                b2 = (y < V - 1) ? pix(y+1, x) : 1'b0;
                exp_q.push_back({11'(x), 10'(y), b2, b1, b0});
                for (int s = 0; s < 3; s++) begin
                    r = y - 1 + s;
                    if (r >= 0 && r < V) addr_q.push_back(r*H + x);
                end
            end
        end
        exp_done = 3*H*V + L + 2 + pause_len;
        end_rel  = (reset_at >= 0) ? 60 : exp_done + 3;
        first_valid = -1; last_valid = -1; done_cyc = -1;
        n_valid = 0; n_done = 0; busy_bad = 0; space_bad = 0; post_rst_bad = 0;

        for (int rel = 0; rel <= end_rel; rel++) begin
            @(negedge clk);
            start_in = (rel == 0) || (poke_start && (rel == 20 || rel == exp_done));
            pause_in = (rel >= pause_at) && (rel < pause_at + pause_len);
            if (reset_at >= 0 && rel == reset_at)     rst_n_in = 1'b0;
            if (reset_at >= 0 && rel == reset_at + 2) rst_n_in = 1'b1;
            #1;
            if (reset_at >= 0 && rel == reset_at) begin
                n_checks++;
                got = {data_out, data_valid_out, hcount_out, vcount_out[8:0]};
                if (got !== 24'h0 || bram_addr_out !== '0 || bram_rd_en_out !== 1'b0 ||
                    busy_out !== 1'b0 || done_out !== 1'b0)
                    $display("FAIL %s async_clear: got data=%b v=%b h=%0d vc=%0d a=%0d en=%b busy=%b done=%b want all 0",
                             name, data_out, data_valid_out, hcount_out, vcount_out,
                             bram_addr_out, bram_rd_en_out, busy_out, done_out);
                else n_pass++;
            end
            exp_busy = (rel >= 1) && (rel < ((reset_at >= 0) ? reset_at : exp_done));
            if (busy_out !== exp_busy) busy_bad++;
            if (reset_at >= 0 && rel >= reset_at) begin
                if (bram_rd_en_out || data_valid_out || done_out) post_rst_bad++;
                if (done_out) n_done++;
                continue;
            end
            if (pause_in) begin
                n_checks++;
                if (bram_rd_en_out !== 1'b0)
                    $display("FAIL %s pause_rd_en: got %b want 0 at t=%0d", name, bram_rd_en_out, rel);
                else n_pass++;
            end
            if (bram_rd_en_out) begin
                n_checks++;
                if (addr_q.size() == 0) begin
                    $display("FAIL %s addr: got %0d want no read at t=%0d", name, bram_addr_out, rel);
                end else begin
                    a = addr_q.pop_front();
                    if (int'(bram_addr_out) !== a)
                        $display("FAIL %s addr: got %0d want %0d at t=%0d", name, bram_addr_out, a, rel);
                    else n_pass++;
                end
            end
            if (data_valid_out) begin
                $display("pix %s x=%0d y=%0d data=%b t=%0d", name, hcount_out, vcount_out, data_out, rel);
                n_valid++;
                if (first_valid < 0) first_valid = rel;
                if (last_valid >= 0 && pause_len == 0 && rel - last_valid != 3) space_bad++;
                last_valid = rel;
                got = {hcount_out, vcount_out, data_out};
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL %s column: got %h want none at t=%0d", name, got, rel);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want)
                        $display("FAIL %s column: got x=%0d y=%0d d=%b want x=%0d y=%0d d=%b",
                                 name, got[23:13], got[12:3], got[2:0], want[23:13], want[12:3], want[2:0]);
                    else n_pass++;
                end
            end
            if (done_out) begin
                n_done++;
                if (done_cyc < 0) done_cyc = rel;
            end
        end
        start_in = 1'b0;
        pause_in = 1'b0;

        n_checks++;
        if (busy_bad != 0) $display("FAIL %s busy_window: got %0d bad cycles want 0", name, busy_bad);
        else n_pass++;
        if (reset_at >= 0) begin
            n_checks++;
            if (post_rst_bad != 0 || n_done != 0)
                $display("FAIL %s after_reset: got %0d activity cycles, %0d done want 0, 0", name, post_rst_bad, n_done);
            else n_pass++;
        end else begin
            n_checks++;
            if (n_valid != H*V) $display("FAIL %s valid_count: got %0d want %0d", name, n_valid, H*V);
            else n_pass++;
            n_checks++;
            if (first_valid != 3 + L + 1) $display("FAIL %s first_valid: got %0d want %0d", name, first_valid, 3 + L + 1);
            else n_pass++;
            n_checks++;
            if (done_cyc != exp_done || n_done != 1)
                $display("FAIL %s done: got t=%0d n=%0d want t=%0d n=1", name, done_cyc, n_done, exp_done);
            else n_pass++;
            n_checks++;
            if (exp_q.size() != 0 || addr_q.size() != 0)
                $display("FAIL %s leftovers: got %0d cols %0d addrs want 0 0", name, exp_q.size(), addr_q.size());
            else n_pass++;
            if (pause_len == 0) begin
                n_checks++;
                if (space_bad != 0) $display("FAIL %s spacing: got %0d gaps not 3 want 0", name, space_bad);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0;
        fill_img(0);
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({data_out, data_valid_out, hcount_out, vcount_out, bram_addr_out, bram_rd_en_out} !== '0)
            $display("FAIL reset_outputs: got data=%b v=%b h=%0d vc=%0d a=%0d en=%b want all 0",
                     data_out, data_valid_out, hcount_out, vcount_out, bram_addr_out, bram_rd_en_out);
        else n_pass++;
        n_checks++;
        if (busy_out !== 1'b0 || done_out !== 1'b0)
            $display("FAIL reset_status: got busy=%b done=%b want 0 0", busy_out, done_out);
        else n_pass++;
        @(negedge clk);
        rst_n_in = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (busy_out !== 1'b0 || bram_rd_en_out !== 1'b0)
            $display("FAIL idle_after_reset: got busy=%b en=%b want 0 0", busy_out, bram_rd_en_out);
        else n_pass++;
    endtask

    task automatic test_all_ones();
        fill_img(1);
        run_frame("ones", -1, 0, -1, 1'b0);
    endtask

    task automatic test_single_pixel();
        fill_img(0);
        img[1*H + 2] = 1'b1;
        run_frame("single", -1, 0, -1, 1'b0);
    endtask

    task automatic test_pause();
        fill_img(2);
        run_frame("pause", 10, 5, -1, 1'b0);
    endtask

    task automatic test_start_while_busy();
        fill_img(2);
        run_frame("busy_start", -1, 0, -1, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_frame("b2b", -1, 0, -1, 1'b0);
    endtask

    task automatic test_reset_mid();
        fill_img(1);
        run_frame("rst_mid", -1, 0, 15, 1'b0);
        run_frame("after_rst", -1, 0, -1, 1'b0);
    endtask

    task automatic test_oob();
        fill_img(0);
        force_one = 1'b1;
        run_frame("oob", -1, 0, -1, 1'b0);
        force_one = 1'b0;
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_single_pixel();
        test_pause();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        test_oob();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
